// File: rtl/lpc.sv
// lpc -- passive LPC bus sniffer.
//
// Watches LFRAME#/LAD[3:0] and decodes memory read/write cycles, plus IO
// cycles when LPC_IO_CAPTURE_EN is defined. Never drives the bus. A
// completed cycle is presented as one record, marked by a one-clock strobe.
//
// Ports
//   lpc_clock        in   LPC bus clock, all sampling on its rising edge
//   lpc_reset        in   async reset, active low
//   lpc_frame        in   LFRAME#, active low
//   lpc_ad[3:0]      in   LAD nibble
//   out_cyctype_dir  out  cycle-type/direction nibble of the last record
//   out_addr[31:0]   out  address of the last record (IO zero-extended)
//   out_data[31:0]   out  data of the last record, byte0 at [7:0]
//   out_data_size    out  data size in bytes (1, 2 or 4)
//   out_clock_enable out  one-clock strobe: a new record is on the outputs
//
// Configuration macro: LPC_IO_CAPTURE_EN -- decode IO cycles (4-nibble
// address, 1 byte, no SIZE nibble). Undefined: IO cycles are ignored.
module lpc (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic        lpc_frame,
  input  logic [3:0]  lpc_ad,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [2:0]  out_data_size,
  output logic        out_clock_enable
);

  // TAR1/TAR2 is the turnaround between the address/data phase and SYNC;
  // ETAR1/ETAR2 is the closing turnaround after which the record is issued.
  typedef enum logic [3:0] {
    IDLE, CTDIR, SIZE, ADDR, TAR1, TAR2, SYNC, DATA, ETAR1, ETAR2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;       // address nibbles left / data nibble index
  logic [3:0]  ct_q, ct_d;         // shadow cycle-type/direction
  logic [2:0]  size_q, size_d;     // shadow size in bytes
  logic [31:0] addr_q, addr_d;     // shadow address
  logic [31:0] data_q, data_d;     // shadow data
  logic [3:0]  o_ct_q, o_ct_d;
  logic [31:0] o_addr_q, o_addr_d;
  logic [31:0] o_data_q, o_data_d;
  logic [2:0]  o_size_q, o_size_d;
  logic        o_en_q, o_en_d;

  logic        wr;
  logic [2:0]  last_nib;

  assign wr = ct_q[1];
  // Index of the final data nibble: 2*size-1 for sizes 1, 2, 4.
  assign last_nib = {size_q[2], size_q[2] | size_q[1], 1'b1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ct_d     = ct_q;
    size_d   = size_q;
    addr_d   = addr_q;
    data_d   = data_q;
    o_ct_d   = o_ct_q;
    o_addr_d = o_addr_q;
    o_data_d = o_data_q;
    o_size_d = o_size_q;
    o_en_d   = 1'b0;

    if (!lpc_frame) begin
      // Frame low overrides everything: START restarts, anything else drops.
      if (lpc_ad == 4'h0) begin
        state_d = CTDIR;
        addr_d  = '0;
        data_d  = '0;
      end else begin
        state_d = IDLE;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        CTDIR: begin
          ct_d   = lpc_ad;
          cnt_d  = 3'd7;
          size_d = 3'd1;
          case (lpc_ad[3:2])
            2'b01: state_d = SIZE;
`ifdef LPC_IO_CAPTURE_EN
            2'b00: begin
              state_d = ADDR;
              cnt_d   = 3'd3;
            end
`endif
            default: state_d = IDLE;
          endcase
        end
        SIZE: begin
          state_d = ADDR;
          case (lpc_ad)
            4'h0:    size_d = 3'd1;
            4'h1:    size_d = 3'd2;
            4'h3:    size_d = 3'd4;
            default: state_d = IDLE;
          endcase
        end
        ADDR: begin
          // Shadow was cleared at START, so a 4-nibble IO address ends up
          // zero-extended.
          addr_d = {addr_q[27:0], lpc_ad};
          cnt_d  = cnt_q - 3'd1;
          if (cnt_q == 3'd0) begin
            cnt_d   = 3'd0;
            state_d = wr ? DATA : TAR1;
          end
        end
        TAR1: state_d = TAR2;
        TAR2: state_d = SYNC;
        SYNC: begin
          cnt_d = 3'd0;
          case (lpc_ad)
            4'h0, 4'hA: state_d = wr ? ETAR1 : DATA;  // error counts as ready
            4'h5, 4'h6: state_d = SYNC;               // short/long wait
            default:    state_d = IDLE;
          endcase
        end
        DATA: begin
          data_d[{cnt_q, 2'b00} +: 4] = lpc_ad;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == last_nib) state_d = wr ? TAR1 : ETAR1;
        end
        ETAR1: state_d = ETAR2;
        ETAR2: begin
          state_d  = IDLE;
          o_en_d   = 1'b1;
          o_ct_d   = ct_q;
          o_addr_d = addr_q;
          o_data_d = data_q;
          o_size_d = size_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ct_q     <= '0;
      size_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      o_ct_q   <= '0;
      o_addr_q <= '0;
      o_data_q <= '0;
      o_size_q <= '0;
      o_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ct_q     <= ct_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      o_ct_q   <= o_ct_d;
      o_addr_q <= o_addr_d;
      o_data_q <= o_data_d;
      o_size_q <= o_size_d;
      o_en_q   <= o_en_d;
    end
  end

  assign out_cyctype_dir  = o_ct_q;
  assign out_addr         = o_addr_q;
  assign out_data         = o_data_q;
  assign out_data_size    = o_size_q;
  assign out_clock_enable = o_en_q;

endmodule

// File: tb/tb_lpc.sv
// Directed bench for lpc: memory read/write, long-wait SYNC, abort, bad
// SIZE/SYNC, reset mid-cycle and IO cycles (with or without the IO macro).
module tb_lpc;
  logic        lpc_clock = 1'b0;
  logic        lpc_reset = 1'b0;
  logic        lpc_frame = 1'b1;
  logic [3:0]  lpc_ad    = 4'hF;
  logic [3:0]  out_cyctype_dir;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [2:0]  out_data_size;
  logic        out_clock_enable;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  lpc dut (
    .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_frame(lpc_frame),
    .lpc_ad(lpc_ad), .out_cyctype_dir(out_cyctype_dir), .out_addr(out_addr),
    .out_data(out_data), .out_data_size(out_data_size),
    .out_clock_enable(out_clock_enable)
  );

  always #5 lpc_clock = ~lpc_clock;

  // Pre-edge value of the strobe, counted once per clock.
  always @(posedge lpc_clock) if (out_clock_enable === 1'b1) strobes++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one nibble for the next rising edge.
  task automatic send(input logic f, input logic [3:0] ad);
    @(negedge lpc_clock);
    lpc_frame = f;
    lpc_ad    = ad;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b1, 4'hF);
  endtask

  task automatic addr_nibs(input logic [31:0] a, input int n);
    for (int i = n - 1; i >= 0; i--) send(1'b1, a[i*4 +: 4]);
  endtask

  task automatic data_nibs(input logic [31:0] d, input int bytes);
    for (int i = 0; i < 2 * bytes; i++) send(1'b1, d[i*4 +: 4]);
  endtask

  task automatic tar();
    send(1'b1, 4'hF);
    send(1'b1, 4'hF);
  endtask

  task automatic mem_head(input logic [3:0] ct, input logic [3:0] sz, input logic [31:0] a);
    send(1'b0, 4'h0);
    send(1'b1, ct);
    send(1'b1, sz);
    addr_nibs(a, 8);
  endtask

  // Called right after the last TAR nibble: strobe must be high on the
  // following cycle only, with the full record.
  task automatic expect_rec(input string tag, input logic [3:0] ct, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] sz);
    idle(1);
    check({tag, "_en"}, 32'(out_clock_enable), 32'd1);
    check({tag, "_ct"}, 32'(out_cyctype_dir), 32'(ct));
    check({tag, "_addr"}, out_addr, a);
    check({tag, "_data"}, out_data, d);
    check({tag, "_size"}, 32'(out_data_size), 32'(sz));
    idle(1);
    check({tag, "_en_drop"}, 32'(out_clock_enable), 32'd0);
  endtask

  initial begin
    int s0;
    #2;
    check("rst_en", 32'(out_clock_enable), 32'd0);
    check("rst_ct", 32'(out_cyctype_dir), 32'd0);
    check("rst_addr", out_addr, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_size", 32'(out_data_size), 32'd0);
    idle(2);
    lpc_reset = 1'b1;
    idle(2);

    // Memory read, 4 bytes.
    mem_head(4'h4, 4'h3, 32'hAFFE7FE5);
    tar();
    send(1'b1, 4'h0);
    data_nibs(32'h1234DF6C, 4);
    tar();
    expect_rec("mrd", 4'h4, 32'hAFFE7FE5, 32'h1234DF6C, 3'd4);
    idle(2);
    check("mrd_count", 32'(strobes), 32'd1);

    // Memory write, 1 byte.
    mem_head(4'h6, 4'h0, 32'h000F0000);
    data_nibs(32'h000000A5, 1);
    tar();
    send(1'b1, 4'h0);
    tar();
    expect_rec("mwr", 4'h6, 32'h000F0000, 32'h000000A5, 3'd1);

    // Read with three long waits, then ready; strobe comes 3 clocks later
    // than an unstalled read, i.e. still exactly one cycle after the TAR.
    mem_head(4'h4, 4'h0, 32'h00001000);
    tar();
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 4'h6);
      check("wait_no_strobe", 32'(out_clock_enable), 32'd0);
    end
    send(1'b1, 4'h0);
    data_nibs(32'h00000042, 1);
    tar();
    expect_rec("wait", 4'h4, 32'h00001000, 32'h00000042, 3'd1);

    // Write, 2 bytes, error SYNC treated as ready.
    mem_head(4'h6, 4'h1, 32'hC0DE0010);
    data_nibs(32'h0000BEEF, 2);
    tar();
    send(1'b1, 4'hA);
    tar();
    expect_rec("errsync", 4'h6, 32'hC0DE0010, 32'h0000BEEF, 3'd2);

    // Abort during ADDR; the rest of the cycle is then ignored.
    s0 = strobes;
    send(1'b0, 4'h0);
    send(1'b1, 4'h4);
    send(1'b1, 4'h0);
    addr_nibs(32'h00000123, 3);
    send(1'b0, 4'hF);
    addr_nibs(32'h00045678, 5);
    tar();
    send(1'b1, 4'h0);
    data_nibs(32'h00000077, 1);
    tar();
    idle(3);
    check("abort_count", 32'(strobes - s0), 32'd0);
    check("abort_addr", out_addr, 32'hC0DE0010);
    check("abort_data", out_data, 32'h0000BEEF);

    // Reserved size nibble and bad SYNC value: no record either way.
    send(1'b0, 4'h0);
    send(1'b1, 4'h4);
    send(1'b1, 4'h2);
    addr_nibs(32'h11111111, 8);
    tar();
    send(1'b1, 4'h0);
    data_nibs(32'h00000011, 1);
    tar();
    mem_head(4'h4, 4'h0, 32'h22222222);
    tar();
    send(1'b1, 4'h3);
    data_nibs(32'h00000022, 1);
    tar();
    idle(3);
    check("bad_count", 32'(strobes - s0), 32'd0);
    check("bad_addr", out_addr, 32'hC0DE0010);

    // Reset asserted during DATA.
    mem_head(4'h4, 4'h0, 32'h33333333);
    tar();
    send(1'b1, 4'h0);
    send(1'b1, 4'h9);
    @(posedge lpc_clock);
    #2 lpc_reset = 1'b0;
    #1;
    check("rst_mid_en", 32'(out_clock_enable), 32'd0);
    check("rst_mid_addr", out_addr, 32'd0);
    check("rst_mid_data", out_data, 32'd0);
    check("rst_mid_ct", 32'(out_cyctype_dir), 32'd0);
    check("rst_mid_size", 32'(out_data_size), 32'd0);
    idle(1);
    lpc_reset = 1'b1;
    s0 = strobes;
    send(1'b1, 4'h9);
    tar();
    idle(3);
    check("rst_mid_count", 32'(strobes - s0), 32'd0);
    check("rst_mid_hold", out_addr, 32'd0);
    mem_head(4'h4, 4'h1, 32'h12345678);
    tar();
    send(1'b1, 4'h0);
    data_nibs(32'h0000CAFE, 2);
    tar();
    expect_rec("post_rst", 4'h4, 32'h12345678, 32'h0000CAFE, 3'd2);

    // IO read.
    s0 = strobes;
    send(1'b0, 4'h0);
    send(1'b1, 4'h0);
    addr_nibs(32'h00000080, 4);
    tar();
    send(1'b1, 4'h0);
    data_nibs(32'h0000005A, 1);
    tar();
`ifdef LPC_IO_CAPTURE_EN
    expect_rec("io", 4'h0, 32'h00000080, 32'h0000005A, 3'd1);
    idle(2);
    check("io_count", 32'(strobes - s0), 32'd1);
`else
    idle(3);
    check("io_count", 32'(strobes - s0), 32'd0);
    check("io_hold_addr", out_addr, 32'h12345678);
    check("io_hold_data", out_data, 32'h0000CAFE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
